// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard controller for the 5-stage MIPS core. It keeps a shadow copy of the
// destination and control bits for the EX/MEM/WB stages. From that copy it
// produces:
//   - registered operand-forwarding selects for the two EX operand muxes,
//   - a one-cycle load-use bubble,
//   - a front-end flush on a taken branch or jump.
// Build option HAZARD_FORWARD_EN:
//   defined     -> full forwarding.
//   not defined -> no forwarding; every dependence on an in-flight producer
//                  stalls until that producer has left WB.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// RUN        | normal flow, all enables on
// LOAD_STALL | hold PC and IF/ID for one cycle, bubble into ID/EX
// FLUSH      | taken branch/jump in EX, squash IF/ID and ID/EX
module hazard_forward_unit (
   input  logic       clock,
   input  logic       resetN,
   input  logic       idValid,
   input  logic [4:0] idRs,
   input  logic [4:0] idRt,
   input  logic       idUsesRs,
   input  logic       idUsesRt,
   input  logic [4:0] idRd,
   input  logic       idRegWrite,
   input  logic       idMemRead,
   input  logic       exTakeBranch,
   output logic [1:0] forwardA,
   output logic [1:0] forwardB,
   output logic       pcWrite,
   output logic       ifIdWrite,
   output logic       ifIdFlush,
   output logic       idExFlush,
   output logic       stallActive
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
   } entry_t;

   state_t state_q, state_d;
   entry_t ex_q, mem_q;
   // Only the EX stage's load flag is ever consulted, so it is not carried further.
   logic   ex_mem_read_q;
   logic   a_ex, b_ex, a_mem, b_mem;
   logic   load_use, load_req, bubble;

   function automatic logic src_match(input entry_t e, input logic [4:0] src,
                                      input logic uses);
      return uses & e.valid & e.reg_write & (e.rd != 5'd0) & (e.rd == src);
   endfunction

   assign a_ex  = src_match(ex_q,  idRs, idUsesRs);
   assign b_ex  = src_match(ex_q,  idRt, idUsesRt);
   assign a_mem = src_match(mem_q, idRs, idUsesRs);
   assign b_mem = src_match(mem_q, idRt, idUsesRt);

`ifdef HAZARD_FORWARD_EN
   // With forwarding, a stall leaves a bubble in EX, so a stall never chains.
   localparam bit RESTALL_OK = 1'b0;
   logic [1:0] sel_a, sel_b;

   assign load_use = idValid & ex_mem_read_q & (a_ex | b_ex);

   // Youngest producer wins: EX (next cycle in MEM) before MEM (next in WB).
   always_comb begin
      sel_a = 2'd0;
      sel_b = 2'd0;
      if (a_ex)       sel_a = 2'd1;
      else if (a_mem) sel_a = 2'd2;
      if (b_ex)       sel_b = 2'd1;
      else if (b_mem) sel_b = 2'd2;
   end

   // Forward selects travel with the instruction into EX; bubbles carry 0.
   always_ff @(posedge clock) begin
      if (!resetN || bubble || !idValid) begin
         forwardA <= 2'd0;
         forwardB <= 2'd0;
      end else begin
         forwardA <= sel_a;
         forwardB <= sel_b;
      end
   end
`else
   // Without forwarding, a dependence keeps stalling while its producer is
   // anywhere up to WB, so back-to-back stalls are expected.
   localparam bit RESTALL_OK = 1'b1;
   entry_t wb_q;
   logic   a_wb, b_wb;

   assign a_wb     = src_match(wb_q, idRs, idUsesRs);
   assign b_wb     = src_match(wb_q, idRt, idUsesRt);
   assign load_use = idValid & (a_ex | b_ex | a_mem | b_mem | a_wb | b_wb);
   assign forwardA = 2'd0;
   assign forwardB = 2'd0;

   // WB shadow entry, needed only to know when a producer has retired.
   always_ff @(posedge clock) begin
      if (!resetN) wb_q <= '0;
      else         wb_q <= mem_q;
   end
`endif

   assign load_req = load_use & (RESTALL_OK | (state_q != LOAD_STALL));
   assign bubble   = (state_d != RUN);

   // Next-state request and its decoded enables; reset forces RUN outputs.
   always_comb begin
      state_d     = RUN;
      pcWrite     = 1'b1;
      ifIdWrite   = 1'b1;
      ifIdFlush   = 1'b0;
      idExFlush   = 1'b0;
      stallActive = 1'b0;
      if (!resetN)           state_d = RUN;
      else if (exTakeBranch) state_d = FLUSH;
      else if (load_req)     state_d = LOAD_STALL;
      case (state_d)
         LOAD_STALL: begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExFlush   = 1'b1;
            stallActive = 1'b1;
         end
         FLUSH: begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
         end
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!resetN) state_q <= RUN;
      else         state_q <= state_d;
   end

   // Shadow pipeline advance; EX takes a bubble on stall or flush.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         ex_q          <= '0;
         ex_mem_read_q <= 1'b0;
         mem_q         <= '0;
      end else begin
         mem_q <= ex_q;
         if (bubble) begin
            ex_q          <= '0;
            ex_mem_read_q <= 1'b0;
         end else begin
            ex_q.valid     <= idValid;
            ex_q.rd        <= idRd;
            ex_q.reg_write <= idRegWrite;
            ex_mem_read_q  <= idValid & idMemRead;
         end
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed test-plan sequences followed by
// random instruction streams, checked against a history-based model.
module tb_hazard_forward_unit;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       resetN = 1'b0;
   logic       idValid = 1'b0;
   logic [4:0] idRs = '0, idRt = '0, idRd = '0;
   logic       idUsesRs = 1'b0, idUsesRt = 1'b0;
   logic       idRegWrite = 1'b0, idMemRead = 1'b0, exTakeBranch = 1'b0;
   logic [1:0] forwardA, forwardB;
   logic       pcWrite, ifIdWrite, ifIdFlush, idExFlush, stallActive;

   int tests = 0;
   int fails = 0;

   // Model: the last three instructions that entered EX, index 1 = youngest.
   logic       h_v  [1:3];
   logic [4:0] h_rd [1:3];
   logic       h_rw [1:3];
   logic       h_mr [1:3];
   logic [1:0] exp_fa, exp_fb;
   logic       exp_stall, exp_flush;
   logic       snap_pc, snap_ifw, snap_iff, snap_idf, snap_st;

   hazard_forward_unit dut (
      .clock(clock), .resetN(resetN), .idValid(idValid),
      .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
      .idRd(idRd), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
      .exTakeBranch(exTakeBranch),
      .forwardA(forwardA), .forwardB(forwardB), .pcWrite(pcWrite),
      .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
      .stallActive(stallActive)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic mdl_match(input int k, input logic [4:0] src, input logic use_it);
      return use_it && h_v[k] && h_rw[k] && (h_rd[k] != 5'd0) && (h_rd[k] == src);
   endfunction

   task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic ut, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br, input logic rst);
      logic any_m, luse, bub;
      logic [1:0] sa, sb;
      @(negedge clock);
      idValid = v; idRs = rs; idRt = rt; idUsesRs = ur; idUsesRt = ut;
      idRd = rd; idRegWrite = rw; idMemRead = mr; exTakeBranch = br; resetN = rst;
      #1;
      any_m = 1'b0;
      for (int k = 1; k <= 3; k++)
         any_m = any_m | mdl_match(k, rs, ur) | mdl_match(k, rt, ut);
      if (FWD) luse = v && h_mr[1] && (mdl_match(1, rs, ur) || mdl_match(1, rt, ut));
      else     luse = v && any_m;
      exp_flush = rst && br;
      exp_stall = rst && !br && luse;
      snap_pc = pcWrite; snap_ifw = ifIdWrite; snap_iff = ifIdFlush;
      snap_idf = idExFlush; snap_st = stallActive;
      check("pcWrite",     {3'b0, pcWrite},     {3'b0, !exp_stall});
      check("ifIdWrite",   {3'b0, ifIdWrite},   {3'b0, !exp_stall});
      check("ifIdFlush",   {3'b0, ifIdFlush},   {3'b0, exp_flush});
      check("idExFlush",   {3'b0, idExFlush},   {3'b0, exp_flush | exp_stall});
      check("stallActive", {3'b0, stallActive}, {3'b0, exp_stall});
      @(posedge clock);
      if (!rst) begin
         for (int k = 1; k <= 3; k++) begin
            h_v[k] = 1'b0; h_rd[k] = '0; h_rw[k] = 1'b0; h_mr[k] = 1'b0;
         end
         exp_fa = 2'd0; exp_fb = 2'd0;
      end else begin
         sa = 2'd0; sb = 2'd0;
         if (FWD) begin
            sa = mdl_match(1, rs, ur) ? 2'd1 : (mdl_match(2, rs, ur) ? 2'd2 : 2'd0);
            sb = mdl_match(1, rt, ut) ? 2'd1 : (mdl_match(2, rt, ut) ? 2'd2 : 2'd0);
         end
         bub = exp_stall || exp_flush || !v;
         exp_fa = bub ? 2'd0 : sa;
         exp_fb = bub ? 2'd0 : sb;
         for (int k = 3; k >= 2; k--) begin
            h_v[k] = h_v[k-1]; h_rd[k] = h_rd[k-1]; h_rw[k] = h_rw[k-1]; h_mr[k] = h_mr[k-1];
         end
         h_v[1] = !bub; h_rd[1] = rd; h_rw[1] = rw; h_mr[1] = mr;
      end
      #1;
      check("forwardA", {2'b0, forwardA}, {2'b0, exp_fa});
      check("forwardB", {2'b0, forwardB}, {2'b0, exp_fb});
   endtask

   task automatic nop();
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Present one instruction, holding it in ID for as long as it stalls.
   task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic ut, input logic [4:0] rd, input logic rw,
                        input logic mr, output int stalls);
      int n;
      stalls = 0;
      n = 0;
      do begin
         step(1'b1, rs, rt, ur, ut, rd, rw, mr, 1'b0, 1'b1);
         if (exp_stall) stalls++;
         n++;
      end while (exp_stall && n < 8);
   endtask

   initial begin
      int s;
      for (int k = 1; k <= 3; k++) begin
         h_v[k] = 1'b0; h_rd[k] = '0; h_rw[k] = 1'b0; h_mr[k] = 1'b0;
      end
      exp_fa = 2'd0; exp_fb = 2'd0; exp_stall = 1'b0; exp_flush = 1'b0;

      // Reset
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_fwdA", {2'b0, forwardA}, 4'd0);
      check("reset_pcWrite", {3'b0, snap_pc}, 4'd1);

      // add $3,$1,$2 ; sub $4,$3,$5
      issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, s);
      issue(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, s);
      check("sub_fwdA", {2'b0, forwardA}, FWD ? 4'd1 : 4'd0);
      check("sub_fwdB", {2'b0, forwardB}, 4'd0);
      check("sub_stalls", s[3:0], FWD ? 4'd0 : 4'd3);
      repeat (3) nop();

      // add $3 ; independent ; or $6,$3,$3
      issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, s);
      issue(5'd8, 5'd9, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, s);
      issue(5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, s);
      check("or_fwdA", {2'b0, forwardA}, FWD ? 4'd2 : 4'd0);
      check("or_fwdB", {2'b0, forwardB}, FWD ? 4'd2 : 4'd0);
      check("or_stalls", s[3:0], FWD ? 4'd0 : 4'd2);
      repeat (3) nop();

      // lw $3 ; add $4,$3,$1
      issue(5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, s);
      issue(5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, s);
      check("lu_stalls", s[3:0], FWD ? 4'd1 : 4'd3);
      check("lu_fwdA", {2'b0, forwardA}, FWD ? 4'd2 : 4'd0);
      repeat (3) nop();

      // Producer of $0, consumer of $0
      issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, s);
      issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, s);
      check("r0_stalls", s[3:0], 4'd0);
      check("r0_fwdA", {2'b0, forwardA}, 4'd0);
      check("r0_fwdB", {2'b0, forwardB}, 4'd0);
      repeat (3) nop();

      // Branch in the same cycle as a load-use
      issue(5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, s);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
      check("br_ifIdFlush", {3'b0, snap_iff}, 4'd1);
      check("br_idExFlush", {3'b0, snap_idf}, 4'd1);
      check("br_pcWrite", {3'b0, snap_pc}, 4'd1);
      check("br_stall", {3'b0, snap_st}, 4'd0);
      repeat (3) nop();

      // Reset during LOAD_STALL
      issue(5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, s);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rs_stall_on", {3'b0, snap_st}, 4'd1);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rs_stall_rst", {3'b0, snap_st}, 4'd0);
      check("rs_ifIdWrite", {3'b0, snap_ifw}, 4'd1);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rs_stall_after", {3'b0, snap_st}, 4'd0);
      check("rs_pcWrite_after", {3'b0, snap_pc}, 4'd1);

      // Random instruction stream
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7) != 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 39) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller for the 5-stage MIPS core. It keeps a shadow pipeline of destination and control bits for the EX, MEM and WB stages. From that state it drives the registered forwarding selects for the two EX-operand 3:1 muxes, inserts a load-use bubble, and flushes the front end on a taken branch or jump. It sits beside the ID/EX register and controls the PC, IF/ID and ID/EX write and flush enables.

## Interface
- No parameters. Register index width is fixed at 5 bits, shadow depth at 3 stages.
- `clock` in 1: single clock, rising edge.
- `resetN` in 1: reset is synchronous and active-low.
- `idValid` in 1: the ID stage holds a real instruction.
- `idRs` in 5: rs field of the instruction in ID.
- `idRt` in 5: rt field of the instruction in ID.
- `idUsesRs` in 1: the instruction in ID reads rs.
- `idUsesRt` in 1: the instruction in ID reads rt.
- `idRd` in 5: destination after the regDst 2:1 mux.
- `idRegWrite` in 1: the instruction in ID writes the register file.
- `idMemRead` in 1: the instruction in ID is a load.
- `exTakeBranch` in 1: taken branch or jump resolved in EX this cycle.
- `forwardA` out 2: select for the EX operand-A mux (0 = register file, 1 = EX/MEM result, 2 = MEM/WB result). Registered.
- `forwardB` out 2: same encoding, for operand B. Registered.
- `pcWrite` out 1: PC update enable.
- `ifIdWrite` out 1: IF/ID register enable.
- `ifIdFlush` out 1: clear IF/ID to a NOP.
- `idExFlush` out 1: load a bubble into ID/EX.
- `stallActive` out 1: FSM is in `LOAD_STALL`.

## Operation
- Shadow entry per stage EX/MEM/WB: `valid`, `rd`, `regWrite`, `memRead`. Every clock the entries advance ID→EX→MEM→WB→discarded.
- The EX entry receives a bubble (`valid=0`) on stall or flush.
- Match rule: a source matches a stage entry only when the entry has `valid & regWrite`, its `rd != 0`, and it equals the source register with the matching `idUses*` bit set. Register 0 never matches.
- Forward select, evaluated in ID and registered into `forwardA`/`forwardB` on the ID→EX transfer:
  - Match against the entry currently in EX (which will be in MEM) → 1.
  - Otherwise, match against the entry currently in MEM (which will be in WB) → 2.
  - Otherwise → 0.
  - When both match, 1 wins (youngest producer).
  - On a bubble the register loads 0.
- Load-use: when `idValid` is set and the EX entry has `memRead` and a source matches it, the request is `LOAD_STALL`.
- FSM states:
  - `RUN`: all enables 1, flushes 0.
  - `LOAD_STALL`: lasts exactly one cycle. `pcWrite=0`, `ifIdWrite=0`, `idExFlush=1`; the EX entry becomes a bubble. Returns to `RUN` on the next cycle.
  - `FLUSH`: entered for the cycle in which `exTakeBranch=1`. `ifIdFlush=1`, `idExFlush=1`, `pcWrite=1`, `ifIdWrite=1`. Returns to `RUN`.
- State outputs are decoded combinationally from the next-state request, so they take effect in the same cycle the hazard is detected.
- Priority: `exTakeBranch` beats load-use. On a simultaneous flush and load-use, no stall occurs; the flush wins and the dependent instruction is discarded.
- After `LOAD_STALL`, the re-evaluated dependent instruction sees the load in MEM and gets forward select 2.

## Timing
- Forward selects are valid from the first clock edge after the instruction enters EX, for the whole EX cycle.
- Flush and stall enables are combinational with zero-cycle latency from the ID/EX inputs and the shadow state.
- Load-use penalty is 1 cycle. Taken-branch penalty is 2 instructions (IF/ID and ID/EX squashed).
- Reset (`resetN=0` at a clock edge):
  - All shadow entries become invalid, FSM goes to `RUN`, `forwardA=forwardB=0`.
  - Outputs during reset: `pcWrite=1`, `ifIdWrite=1`, `ifIdFlush=0`, `idExFlush=0`, `stallActive=0`.
  - Reset in the middle of `LOAD_STALL` or `FLUSH` aborts it; no residual stall follows.
- `idValid=0` does not request a stall; its entry advances as a bubble.

## Configuration
- `HAZARD_FORWARD_EN` defined: full forwarding as described above.
- Not defined:
  - `forwardA`/`forwardB` are held at 0.
  - Any source match against a valid EX, MEM or WB entry (not only loads) requests `LOAD_STALL`. It repeats one cycle at a time until no match remains.
  - Flush behaviour is unchanged.

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` → for `sub` in EX, `forwardA=1`, `forwardB=0`, no stall.
- `add $3`, independent instruction, `or $6,$3,$3` → `forwardA=forwardB=2`.
- `lw $3` then `add $4,$3,$1` → one cycle with `pcWrite=0`, `ifIdWrite=0`, `idExFlush=1`, `stallActive=1`; then `forwardA=2`.
- Producer writes `$0` (`idRd=0`, `idRegWrite=1`), consumer reads `$0` → selects 0, no stall.
- `exTakeBranch=1` in the same cycle as a load-use → `ifIdFlush=idExFlush=1`, `pcWrite=1`, `stallActive=0`. Separately, `resetN=0` during `LOAD_STALL` → next cycle in `RUN` with all reset output values.
- `HAZARD_FORWARD_EN` undefined: `add $3` then `sub $4,$3,$5` → 3 consecutive stall cycles, selects stay 0.
